lcd_sequencer: RTL
==================

# lcd_sequencer

Hardware sequencer for the HD44780-compatible character LCD on the `lcd_external_*` pins of the Nios II system. After reset it runs the power-up initialisation sequence by itself. It then accepts one command or character byte at a time over a valid/ready interface and generates the RS/RW/E/data waveform and execution wait for each byte. It sits between the CPU-side LCD peripheral logic and the board pins, so software no longer bit-bangs E timing.

## Interface
Parameters (all in clock cycles):
- `POWERUP_CYC`, default 750000: wait after reset before the first init write (15 ms at 50 MHz).
- `EXEC_CYC`, default 2000: post-write wait for normal commands and characters (40 µs).
- `CLEAR_CYC`, default 82000: post-write wait for clear/home (1.64 ms).
- `E_SETUP_CYC`, default 2: RS/RW/data valid before E rises.
- `E_HIGH_CYC`, default 12: E high width.
- `E_HOLD_CYC`, default 2: RS/RW/data held after E falls.

Ports:
- `clk_clk`  in  1  system clock.
- `reset_reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  requester has a byte.
- `cmd_ready`  out  1  sequencer accepts a byte this cycle.
- `cmd_rs`  in  1  0 = instruction, 1 = data/character.
- `cmd_data`  in  8  byte to write.
- `init_done`  out  1  init sequence complete; stays high until reset.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `lcd_external_RS`  out  1  register select.
- `lcd_external_RW`  out  1  0 = write, 1 = read.
- `lcd_external_data`  inout  8  LCD data bus.
- `lcd_external_E`  out  1  enable strobe.

## Operation
- **States:** PWRUP → LOAD → SETUP → E_HI → HOLD → WAIT → (LOAD if init incomplete, else IDLE). A handshake in IDLE goes to SETUP.
- **Init ROM:** RS=0, bytes 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06. Each byte uses a fixed WAIT. `init_done` rises on entry to IDLE after the last byte's WAIT.
- **Handshake:** `cmd_ready` = (state==IDLE). A transfer occurs on a rising edge with `cmd_valid && cmd_ready`. `cmd_rs` and `cmd_data` are registered at that edge. `cmd_ready` is 0 the following cycle. `cmd_valid` is ignored outside IDLE.
- **WAIT length:** `CLEAR_CYC` if RS=0 and data ∈ {0x01, 0x02, 0x03}. Otherwise `EXEC_CYC`, including for 0x00.
- **Pins during a write:** RW=0 and the data bus is driven with the registered byte. RS and data are held constant from SETUP through the end of HOLD. E is 1 only in E_HI.
- **Counter:** one shared down-counter, wide enough for max(`POWERUP_CYC`, `CLEAR_CYC`). It is reloaded on every state entry.

## Timing
- **Reset values (asynchronous):** RS=0, RW=0, E=0, data driven 0x00, `cmd_ready`=0, `init_done`=0, `busy`=1, state=PWRUP.
- **Per-byte sequence:** a byte accepted at edge k has pins valid from k+1. E is high for cycles k+S+1 … k+S+H. `cmd_ready` is high again at cycle k+S+H+D+W+1, where S/H/D are the three E parameters and W is the WAIT length.
- **Throughput:** back-to-back commands complete one per S+H+D+W+1 cycles. There is never an E pulse before the previous WAIT has ended.
- **First init strobe:** E rises `POWERUP_CYC`+`E_SETUP_CYC` cycles after reset deasserts.
- **Reset mid-operation:** E drops immediately, any captured byte is discarded, and the full power-up wait and init restart.
- **Zero parameters:** `E_*_CYC` of 0 is treated as 1.

## Configuration
- **Macro `LCD_BUSY_POLL_EN`, defined:** the WAIT of user commands (not init bytes) is replaced by busy-flag polling, with this loop:
  - Set RS=0, RW=1, and release the data bus (high-Z).
  - Run SETUP / E_HI / HOLD.
  - Sample `lcd_external_data[7]` on the last E_HI cycle.
  - Repeat while the sample is 1.
- **Poll timeout:** if `CLEAR_CYC` cycles elapse since polling began, polling stops and the FSM goes to IDLE regardless.
- **Exit from polling:** RW returns to 0 and the bus is re-driven on entry to IDLE.
- **Macro undefined:** only fixed delays are used, RW is constantly 0, and the bus is always driven.

## Test plan
Bench parameters: POWERUP=100, EXEC=20, CLEAR=80, S=2, H=4, D=2.
1. **Power-up init:** release reset → no E for 100 cycles, then 6 E pulses of width 4 with RS=0 carrying 38, 38, 38, 0C, 01, 06. The gap after 01 is 80 cycles and after the others 20. `init_done` rises, then `cmd_ready`=1.
2. **Character write:** send RS=1, 0x41 → one E pulse, 4 cycles wide. RS=1 and data=0x41 are stable for 2 cycles before and 2 after the pulse. `cmd_ready` returns 29 cycles after the accepting edge.
3. **Clear:** send RS=0, 0x01 → `cmd_ready` returns 89 cycles after acceptance. Sending 0x80 instead gives 29.
4. **Back-to-back:** hold `cmd_valid` high with 0x48, 0x49, 0x21 → each is accepted only when `cmd_ready` is high. Output order is preserved, and E pulses are spaced exactly 29 cycles apart.
5. **Reset during a write:** assert reset during E_HI of a user write → E=0 in the same cycle and `init_done`=0. After release, the full init repeats.
6. **Busy polling (`LCD_BUSY_POLL_EN`):** the LCD model drives D7=1 for 3 reads, then 0 → 4 read strobes with RW=1 and the bus at high-Z, then IDLE with RW=0. A model stuck at D7=1 → IDLE reached after 80 cycles of polling.

Source files
------------

// File: rtl/lcd_sequencer.sv
// rtl/lcd_sequencer.sv - HD44780 power-up init and byte-write sequencer with E strobe timing
// Optional busy-flag polling of user commands: define LCD_BUSY_POLL_EN.
module lcd_sequencer #(
  parameter int POWERUP_CYC = 750000,
  parameter int EXEC_CYC    = 2000,
  parameter int CLEAR_CYC   = 82000,
  parameter int E_SETUP_CYC = 2,
  parameter int E_HIGH_CYC  = 12,
  parameter int E_HOLD_CYC  = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_external_RS,
  output logic       lcd_external_RW,
  inout  wire  [7:0] lcd_external_data,
  output logic       lcd_external_E
);
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int S_N  = max2(E_SETUP_CYC, 1);
  localparam int H_N  = max2(E_HIGH_CYC, 1);
  localparam int D_N  = max2(E_HOLD_CYC, 1);
  localparam int EX_N = max2(EXEC_CYC, 1);
  localparam int CL_N = max2(CLEAR_CYC, 1);
  localparam int PW_N = max2(POWERUP_CYC, 2);
  localparam int MAX_CYC = max2(max2(max2(PW_N, CL_N), max2(EX_N, S_N)), max2(H_N, D_N));
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {PWRUP, LOAD, SETUP, E_HI, HOLD, WAIT, IDLE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wait_ld;
  logic [2:0]    idx;
  logic [7:0]    data_q;

  function automatic logic [7:0] init_byte(input logic [2:0] i);
    case (i)
      3'd3:    return 8'h0C;
      3'd4:    return 8'h01;
      3'd5:    return 8'h06;
      default: return 8'h38;
    endcase
  endfunction

  // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
  always_comb begin
    wait_ld = CW'(EX_N - 1);
    if (!lcd_external_RS && (data_q == 8'h01 || data_q == 8'h02 || data_q == 8'h03))
      wait_ld = CW'(CL_N - 1);
  end

`ifdef LCD_BUSY_POLL_EN
  logic          rw_q;
  logic          drive_q;
  logic          polling;
  logic          busy_flag;
  logic [CW-1:0] ptimer;
  assign lcd_external_RW   = rw_q;
  assign lcd_external_data = drive_q ? data_q : 8'hzz;
`else
  assign lcd_external_RW   = 1'b0;
  assign lcd_external_data = data_q;
`endif

  // PWRUP plus the one-cycle LOAD together span POWERUP_CYC cycles.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state           <= PWRUP;
      cnt             <= CW'(PW_N - 2);
      idx             <= '0;
      data_q          <= '0;
      lcd_external_RS <= 1'b0;
      lcd_external_E  <= 1'b0;
      cmd_ready       <= 1'b0;
      init_done       <= 1'b0;
      busy            <= 1'b1;
`ifdef LCD_BUSY_POLL_EN
      rw_q            <= 1'b0;
      drive_q         <= 1'b1;
      polling         <= 1'b0;
      busy_flag       <= 1'b0;
      ptimer          <= '0;
`endif
    end else begin
      case (state)
        PWRUP: begin
          if (cnt == '0) begin
            state <= LOAD;
            cnt   <= '0;
          end else cnt <= cnt - 1'b1;
        end
        LOAD: begin
          lcd_external_RS <= 1'b0;
          data_q          <= init_byte(idx);
          state           <= SETUP;
          cnt             <= CW'(S_N - 1);
        end
        SETUP: begin
          if (cnt == '0) begin
            state          <= E_HI;
            lcd_external_E <= 1'b1;
            cnt            <= CW'(H_N - 1);
          end else cnt <= cnt - 1'b1;
        end
        E_HI: begin
          if (cnt == '0) begin
            state          <= HOLD;
            lcd_external_E <= 1'b0;
            cnt            <= CW'(D_N - 1);
`ifdef LCD_BUSY_POLL_EN
            busy_flag      <= lcd_external_data[7];
`endif
          end else cnt <= cnt - 1'b1;
        end
        HOLD: begin
          if (cnt == '0) begin
`ifdef LCD_BUSY_POLL_EN
            if (polling) begin
              if (busy_flag) begin
                state <= SETUP;
                cnt   <= CW'(S_N - 1);
              end else begin
                state     <= IDLE;
                cnt       <= '0;
                rw_q      <= 1'b0;
                drive_q   <= 1'b1;
                polling   <= 1'b0;
                cmd_ready <= 1'b1;
                busy      <= 1'b0;
              end
            end else if (init_done) begin
              state           <= SETUP;
              cnt             <= CW'(S_N - 1);
              lcd_external_RS <= 1'b0;
              rw_q            <= 1'b1;
              drive_q         <= 1'b0;
              polling         <= 1'b1;
              ptimer          <= CW'(CL_N - 1);
            end else
`endif
            begin
              state <= WAIT;
              cnt   <= wait_ld;
            end
          end else cnt <= cnt - 1'b1;
        end
        WAIT: begin
          if (cnt == '0) begin
            if (init_done || idx == 3'd5) begin
              state     <= IDLE;
              cnt       <= '0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              init_done <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              state <= LOAD;
              cnt   <= '0;
            end
          end else cnt <= cnt - 1'b1;
        end
        IDLE: begin
          if (cmd_valid) begin
            lcd_external_RS <= cmd_rs;
            data_q          <= cmd_data;
            state           <= SETUP;
            cnt             <= CW'(S_N - 1);
            cmd_ready       <= 1'b0;
            busy            <= 1'b1;
          end
        end
        default: begin
          state <= PWRUP;
          cnt   <= CW'(PW_N - 2);
        end
      endcase
`ifdef LCD_BUSY_POLL_EN
      // A display that never clears its busy flag must not hang the sequencer.
      if (polling) begin
        if (ptimer == '0) begin
          state          <= IDLE;
          cnt            <= '0;
          lcd_external_E <= 1'b0;
          rw_q           <= 1'b0;
          drive_q        <= 1'b1;
          polling        <= 1'b0;
          cmd_ready      <= 1'b1;
          busy           <= 1'b0;
        end else ptimer <= ptimer - 1'b1;
      end
`endif
    end
  end

endmodule
